// File: rtl/mem_responder.sv
// Block-RAM backed stand-in for the SDRAM controller: init delay, per-access busy latency, one-cycle read return.
// Optional build macro MEM_RESPONDER_FAULT_EN: reads of FAULT_ADDR return stored data with bit 0 inverted.
module mem_responder #(
    parameter int ADDR_WIDTH     = 24,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int INIT_CYCLES    = 64,
    parameter int WR_LATENCY     = 3,
    parameter int RD_LATENCY     = 5,
    parameter int FAULT_ADDR     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_enable_i,
    input  logic                  wr_enable_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [15:0]           wr_data_i,
    output logic                  busy_o,
    output logic                  rd_ready_o,
    output logic [15:0]           rd_data_o,
    output logic                  protocol_err_o
);
    localparam int DEPTH   = 2 ** MEM_ADDR_WIDTH;
    localparam int LAT_MAX = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
    localparam int CNT_MAX = (INIT_CYCLES > LAT_MAX) ? INIT_CYCLES : LAT_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_LATENCY);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] FAULT_ADDR_W = ADDR_WIDTH'(FAULT_ADDR);

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    logic [1:0]                state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [ADDR_WIDTH-1:0]     addr_reg;
    logic [15:0]               wdata_reg;
    logic [15:0]               mem_rd_reg;
    logic [15:0]               rd_data_reg;
    logic [15:0]               fault_mask;
    logic                      rd_ready_reg;
    logic                      perr_reg;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] rd_idx;
    logic [15:0]               mem [0:DEPTH-1];

    assign busy_o         = (state_reg != S_IDLE);
    assign rd_ready_o     = rd_ready_reg;
    assign rd_data_o      = rd_data_reg;
    assign protocol_err_o = perr_reg;

`ifdef MEM_RESPONDER_FAULT_EN
    assign fault_mask = {15'd0, (addr_reg == FAULT_ADDR_W)};
`else
    logic unused_fault;
    assign fault_mask   = 16'd0;
    assign unused_fault = ^{addr_reg[ADDR_WIDTH-1:MEM_ADDR_WIDTH], FAULT_ADDR_W};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_INIT;
            cnt_reg      <= INIT_LOAD;
            rd_ready_reg <= 1'b0;
            rd_data_reg  <= 16'd0;
            perr_reg     <= 1'b0;
        end else begin
            rd_ready_reg <= 1'b0;
            case (state_reg)
                S_INIT: begin
                    if (cnt_reg == CNT_LAST) state_reg <= S_IDLE;
                    else                     cnt_reg   <= cnt_reg - CNT_LAST;
                end
                S_IDLE: begin
                    // Write wins a simultaneous request; the collision is flagged until reset.
                    if (wr_enable_i) begin
                        state_reg <= S_WRITE;
                        cnt_reg   <= WR_LOAD;
                        if (rd_enable_i) perr_reg <= 1'b1;
                    end else if (rd_enable_i) begin
                        state_reg <= S_READ;
                        cnt_reg   <= RD_LOAD;
                    end
                end
                S_WRITE: begin
                    if (cnt_reg == CNT_LAST) state_reg <= S_IDLE;
                    else                     cnt_reg   <= cnt_reg - CNT_LAST;
                end
                S_READ: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg    <= S_IDLE;
                        rd_ready_reg <= 1'b1;
                        rd_data_reg  <= mem_rd_reg ^ fault_mask;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_LAST;
                    end
                end
                default: state_reg <= S_INIT;
            endcase
        end
    end

    // Request fields are captured on every IDLE cycle; the last one before leaving IDLE is the accepted request.
    always_ff @(posedge clk) begin
        if (state_reg == S_IDLE) begin
            addr_reg  <= addr_i;
            wdata_reg <= wr_data_i;
        end
    end

    // The array is read continuously so the word is ready even with a one-cycle read latency.
    assign rd_idx = (state_reg == S_IDLE) ? addr_i[MEM_ADDR_WIDTH-1:0] : addr_reg[MEM_ADDR_WIDTH-1:0];
    assign mem_we = !rst && (state_reg == S_WRITE) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_reg[MEM_ADDR_WIDTH-1:0]] <= wdata_reg;
        mem_rd_reg <= mem[rd_idx];
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the SDRAM-controller request interface (rd_enable/wr_enable/busy/rd_ready).
- Stands in for the real SDRAM controller so the tester state machine can run on FPGA block RAM or in simulation.
- Models init delay, per-access busy latency and single-cycle read-data return.

Parameters:
ADDR_WIDTH, 24, request address width seen on the interface
MEM_ADDR_WIDTH, 10, backing-store index width; depth = 2**MEM_ADDR_WIDTH words of 16 bits
INIT_CYCLES, 64, cycles busy_o is held high after reset (>=1)
WR_LATENCY, 3, busy cycles per write (>=1)
RD_LATENCY, 5, busy cycles per read (>=1)
FAULT_ADDR, 0, address whose read data is corrupted when MEM_RESPONDER_FAULT_EN is defined

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
rd_enable_i  input  1  read request
wr_enable_i  input  1  write request
addr_i  input  ADDR_WIDTH  request address
wr_data_i  input  16  write data
busy_o  output  1  responder busy; requests are ignored while high
rd_ready_o  output  1  one-cycle pulse; rd_data_o valid
rd_data_o  output  16  read data, held until the next read completes
protocol_err_o  output  1  sticky; set when rd_enable_i and wr_enable_i are both sampled high in IDLE

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: busy_o=1, rd_ready_o=0, rd_data_o=0, protocol_err_o=0. State is INIT with the init counter loaded to INIT_CYCLES. Memory contents are not reset.
- States: INIT, IDLE, WRITE, READ.
- INIT:
  - busy_o=1; the counter decrements each cycle.
  - At count 1 the next state is IDLE, so busy_o is high for exactly INIT_CYCLES cycles after rst is released.
  - Enables are ignored.
- IDLE:
  - busy_o=0. The enables are sampled each cycle.
  - On acceptance cycle T: latch addr_i[MEM_ADDR_WIDTH-1:0] and wr_data_i, and load the latency counter.
  - wr_enable_i=1 → WRITE. rd_enable_i=1 → READ.
  - Both high: write wins and protocol_err_o sets (remains set until rst).
- WRITE:
  - busy_o=1 for cycles T+1..T+WR_LATENCY.
  - The array is written on the edge ending cycle T+WR_LATENCY.
  - IDLE at T+WR_LATENCY+1 with busy_o=0.
- READ:
  - busy_o=1 for cycles T+1..T+RD_LATENCY. The array is read at the latched index.
  - At T+RD_LATENCY+1: busy_o=0, rd_ready_o=1 for that single cycle, and rd_data_o is updated. State is IDLE.
- Ordering rule: busy_o never falls later than the rd_ready_o pulse. A requester that waits only on rd_ready_o therefore always sees busy_o low before issuing its next request.
- Enables held high while busy_o=1 are ignored; only the IDLE-cycle sample counts.
- A request present in the cycle busy_o falls (IDLE, including the rd_ready_o cycle) is accepted, giving back-to-back operation.
- Address aliasing: upper address bits are dropped. Addresses A and A+2**MEM_ADDR_WIDTH map to the same word.
- Reset mid-operation: any in-flight write is abandoned and the array is not written. No rd_ready_o pulse is produced. The block restarts in INIT.
- Read of a never-written word returns array contents (X in simulation). The bench must write before reading.

Optional Feature:
- Macro: MEM_RESPONDER_FAULT_EN.
- Defined: a read whose full latched addr_i equals FAULT_ADDR returns stored data with bit 0 inverted. Writes are unaffected. This exercises the requester's FAIL path.
- Undefined: FAULT_ADDR is unused and read data is always the stored data.

Test Plan:
- Reset, then hold wr_enable_i=1 with INIT_CYCLES=64 → busy_o=1 for exactly 64 cycles after rst falls, and no write occurs. The write is accepted on the first IDLE cycle.
- Write addr=0x000005 data=0xBEEF, then read addr=0x000005 (WR_LATENCY=3, RD_LATENCY=5) → busy_o high 3 cycles for the write. For the read, busy_o is high 5 cycles, then rd_ready_o is a 1-cycle pulse with rd_data_o=0xBEEF and busy_o=0 in the same cycle.
- Write 0x1111 to addr 0x000400, then read addr 0x000000 (MEM_ADDR_WIDTH=10) → rd_data_o=0x1111 (alias).
- Assert rd_enable_i and wr_enable_i together in IDLE, addr=3 data=0xA5A5 → protocol_err_o=1 and stays set. A subsequent read of addr 3 returns 0xA5A5.
- Assert rst during READ busy cycle 2 → no rd_ready_o pulse, busy_o=1, INIT restarts. A write interrupted the same way leaves the prior word unchanged.
- With MEM_RESPONDER_FAULT_EN defined and FAULT_ADDR=7: write 0x0010 to addr 7, read it back → rd_data_o=0x0011. Without the macro → 0x0010.
